alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Initiator side of the CPU ALU interface.
- Accepts one operation per request from the decode stage on a valid/ready channel.
- Drives the ALU operand, opcode and alu_active lines, then captures the combinational result or the registered compare flags.
- Returns a tagged response on a second valid/ready channel; sits between the decoder and the ALU inside the cpu block.

Parameters:
DATA_WIDTH, 16, operand/result width (matches ALU)
OPCODE_WIDTH, 4, opcode width (matches ALU)
TAG_WIDTH, 4, destination-register tag carried request to response
CNT_WIDTH, 16, completed-operation counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when both high
req_opcode  in  OPCODE_WIDTH  operation
req_op_a  in  DATA_WIDTH  operand A
req_op_b  in  DATA_WIDTH  operand B
req_tag  in  TAG_WIDTH  destination tag
alu_op_a  out  DATA_WIDTH  to ALU op_a
alu_op_b  out  DATA_WIDTH  to ALU op_b
alu_opcode  out  OPCODE_WIDTH  to ALU opcode
alu_active  out  1  to ALU alu_active
alu_result  in  DATA_WIDTH  from ALU result
alu_equal  in  1  from ALU equal
alu_less  in  1  from ALU less
alu_greater  in  1  from ALU greater
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when both high
rsp_result  out  DATA_WIDTH  captured result (0 for compare/illegal)
rsp_flags  out  3  {greater,less,equal}; 0 for non-compare
rsp_tag  out  TAG_WIDTH  echoed req_tag
rsp_err  out  1  illegal opcode
op_count  out  CNT_WIDTH  completed responses, saturating

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is IDLE.
  - All registered outputs are 0: alu_op_a/b, alu_opcode, alu_active, rsp_*, op_count.
  - Any in-flight operation is dropped.
- Opcodes:
  - 0000-0111 are arithmetic/logic; the result is valid combinationally in the same cycle.
  - 1000 is CMP; flags are valid only in the cycle after alu_active, because the ALU clears its flags whenever it is not active on CMP.
  - 1001-1111 are illegal.
- req_ready = (state==IDLE) || (state==RESP && rsp_ready).
- FSM:
  - IDLE: on req_valid&&req_ready, latch opcode, operands and tag into the alu_* registers and the tag register; go to EXEC.
  - EXEC (exactly 1 cycle):
    - Legal opcode: alu_active=1.
    - Arithmetic: rsp_result<=alu_result, rsp_flags<=0, rsp_err<=0; go to RESP.
    - CMP: go to FLAG.
    - Illegal: alu_active=0, rsp_result<=0, rsp_flags<=0, rsp_err<=1; go to RESP.
  - FLAG (1 cycle): alu_active=0; rsp_flags<={alu_greater,alu_less,alu_equal}, rsp_result<=0, rsp_err<=0; go to RESP.
  - RESP: rsp_valid=1; all rsp_* stay stable until handshake. On handshake: op_count increments, saturating at all-ones. Then go to EXEC if a new request is accepted the same cycle, else go to IDLE.
- alu_active is high only in EXEC; it is never high for two consecutive cycles.
- alu_op_a, alu_op_b and alu_opcode hold their latched values outside EXEC (no toggling).
- Latency from the accept edge T:
  - arithmetic/illegal: rsp_valid at T+2
  - CMP: rsp_valid at T+3
- Best-case throughput: one arithmetic op per 2 cycles (back-to-back accept in RESP).
- Width: the ALU result is taken as-is; multiply is already truncated to DATA_WIDTH; no sign extension.
- Reset mid-operation (EXEC, FLAG or RESP): outputs clear immediately; the first request after release is accepted normally.
- req_valid while not ready: no effect; the requester holds its data.

Decomposition:
- Package cpu_alu_pkg contains:
  - opcode localparams OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_NEG, OP_CMP
  - flag index constants FLAG_EQ=0, FLAG_LT=1, FLAG_GT=2
  - state enum {IDLE, EXEC, FLAG, RESP}
  - an is_legal/is_cmp helper function
- No sub-module. The bench instantiates the existing ALU alongside the DUT to close the loop.

Test Plan:
- ADD a=0x0003 b=0x0004 tag=5, accept at T, rsp_ready=1 -> alu_active high only at T+1; rsp_valid at T+2 with result 0x0007, flags 000, tag 5, err 0; op_count=1.
- CMP a=0x0005 b=0x0009 -> rsp_valid at T+3, flags 010, result 0x0000; repeat with a=b=0x1234 -> flags 001; a=0xFFFF b=0x0001 -> flags 100.
- SUB a=0x0001 b=0x0002 with rsp_ready low 4 cycles:
  - While stalled: response holds result 0xFFFF; req_ready stays 0.
  - Raise rsp_ready with a pending AND 0x00F0&0x0FF0: accepted that cycle; alu_active the next cycle; response 0x00F0.
- Illegal opcode 1010 -> alu_active never asserts; rsp_valid at T+2 with err 1, result 0, flags 000.
- Reset: assert rst_n=0 while in FLAG -> rsp_valid, alu_active and op_count read 0 immediately. After release, NOT a=0x00FF -> result 0xFF00.
- Saturation: CNT_WIDTH=2, 5 back-to-back ops -> op_count reads 3 after the third response and stays 3.

Source files
------------

// File: rtl/cpu_alu_pkg.sv
// rtl/cpu_alu_pkg.sv - shared opcodes, flag indices and FSM states for the ALU issue path
package cpu_alu_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_AND = 4'b0011;
   localparam logic [3:0] OP_OR  = 4'b0100;
   localparam logic [3:0] OP_XOR = 4'b0101;
   localparam logic [3:0] OP_NOT = 4'b0110;
   localparam logic [3:0] OP_NEG = 4'b0111;
   localparam logic [3:0] OP_CMP = 4'b1000;

   localparam int FLAG_EQ = 0;
   localparam int FLAG_LT = 1;
   localparam int FLAG_GT = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      FLAG = 2'd2,
      RESP = 2'd3
   } state_t;

   function automatic logic is_legal(input logic [3:0] op);
      return op <= OP_CMP;
   endfunction

   function automatic logic is_cmp(input logic [3:0] op);
      return op == OP_CMP;
   endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issues one decoded op to the ALU and returns a tagged response
module alu_issue_ctrl
   import cpu_alu_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int OPCODE_WIDTH = 4,
   parameter int TAG_WIDTH    = 4,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [OPCODE_WIDTH-1:0] req_opcode,
   input  logic [DATA_WIDTH-1:0]   req_op_a,
   input  logic [DATA_WIDTH-1:0]   req_op_b,
   input  logic [TAG_WIDTH-1:0]    req_tag,
   output logic [DATA_WIDTH-1:0]   alu_op_a,
   output logic [DATA_WIDTH-1:0]   alu_op_b,
   output logic [OPCODE_WIDTH-1:0] alu_opcode,
   output logic                    alu_active,
   input  logic [DATA_WIDTH-1:0]   alu_result,
   input  logic                    alu_equal,
   input  logic                    alu_less,
   input  logic                    alu_greater,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_result,
   output logic [2:0]              rsp_flags,
   output logic [TAG_WIDTH-1:0]    rsp_tag,
   output logic                    rsp_err,
   output logic [CNT_WIDTH-1:0]    op_count
);

   state_t               state;
   logic [TAG_WIDTH-1:0] tag_q;
   logic                 accept;
   logic [2:0]           cmp_flags;

   assign req_ready = (state == IDLE) || (state == RESP && rsp_ready);
   assign accept    = req_valid && req_ready;

   always_comb begin
      cmp_flags          = '0;
      cmp_flags[FLAG_EQ] = alu_equal;
      cmp_flags[FLAG_LT] = alu_less;
      cmp_flags[FLAG_GT] = alu_greater;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tag_q      <= '0;
         alu_op_a   <= '0;
         alu_op_b   <= '0;
         alu_opcode <= '0;
         alu_active <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         rsp_tag    <= '0;
         rsp_err    <= 1'b0;
         op_count   <= '0;
      end else begin
         // alu_active is a one-cycle pulse, so it can never stay high across EXEC
         alu_active <= 1'b0;

         if (accept) begin
            alu_op_a   <= req_op_a;
            alu_op_b   <= req_op_b;
            alu_opcode <= req_opcode;
            tag_q      <= req_tag;
            alu_active <= is_legal(req_opcode);
         end

         case (state)
            IDLE: begin
               if (accept) state <= EXEC;
            end
            EXEC: begin
               if (is_cmp(alu_opcode)) begin
                  state <= FLAG;
               end else begin
                  rsp_result <= is_legal(alu_opcode) ? alu_result : '0;
                  rsp_flags  <= '0;
                  rsp_err    <= !is_legal(alu_opcode);
                  rsp_tag    <= tag_q;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end
            end
            FLAG: begin
               // ALU flags are registered inside the ALU, so they land one cycle after EXEC
               rsp_flags  <= cmp_flags;
               rsp_result <= '0;
               rsp_err    <= 1'b0;
               rsp_tag    <= tag_q;
               rsp_valid  <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (op_count != '1) op_count <= op_count + CNT_WIDTH'(1);
                  state <= accept ? EXEC : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed bench for alu_issue_ctrl with a behavioural ALU in the loop
module tb_alu_issue_ctrl;
   import cpu_alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [3:0]  req_opcode = '0;
   logic [15:0] req_op_a = '0;
   logic [15:0] req_op_b = '0;
   logic [3:0]  req_tag = '0;
   logic        rsp_ready = 1'b1;

   logic        req_ready, alu_active, rsp_valid, rsp_err;
   logic [15:0] alu_op_a, alu_op_b, rsp_result;
   logic [3:0]  alu_opcode, rsp_tag;
   logic [2:0]  rsp_flags;
   logic [15:0] op_count;

   logic        s_req_ready, s_alu_active, s_rsp_valid, s_rsp_err;
   logic [15:0] s_alu_op_a, s_alu_op_b, s_rsp_result;
   logic [3:0]  s_alu_opcode, s_rsp_tag;
   logic [2:0]  s_rsp_flags;
   logic [1:0]  s_op_count;

   logic [15:0] alu_result;
   logic        alu_equal, alu_less, alu_greater;
   logic [31:0] prod;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   alu_issue_ctrl dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_op_a(req_op_a), .req_op_b(req_op_b), .req_tag(req_tag),
      .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_opcode(alu_opcode), .alu_active(alu_active),
      .alu_result(alu_result), .alu_equal(alu_equal), .alu_less(alu_less), .alu_greater(alu_greater),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .rsp_tag(rsp_tag), .rsp_err(rsp_err), .op_count(op_count)
   );

   alu_issue_ctrl #(.CNT_WIDTH(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
      .req_opcode(req_opcode), .req_op_a(req_op_a), .req_op_b(req_op_b), .req_tag(req_tag),
      .alu_op_a(s_alu_op_a), .alu_op_b(s_alu_op_b), .alu_opcode(s_alu_opcode), .alu_active(s_alu_active),
      .alu_result(alu_result), .alu_equal(alu_equal), .alu_less(alu_less), .alu_greater(alu_greater),
      .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(s_rsp_result), .rsp_flags(s_rsp_flags),
      .rsp_tag(s_rsp_tag), .rsp_err(s_rsp_err), .op_count(s_op_count)
   );

   // Behavioural ALU: combinational result, compare flags registered and cleared when not comparing
   assign prod = alu_op_a * alu_op_b;
   always_comb begin
      alu_result = '0;
      case (alu_opcode)
         OP_ADD: alu_result = alu_op_a + alu_op_b;
         OP_SUB: alu_result = alu_op_a - alu_op_b;
         OP_MUL: alu_result = prod[15:0];
         OP_AND: alu_result = alu_op_a & alu_op_b;
         OP_OR:  alu_result = alu_op_a | alu_op_b;
         OP_XOR: alu_result = alu_op_a ^ alu_op_b;
         OP_NOT: alu_result = ~alu_op_a;
         OP_NEG: alu_result = -alu_op_a;
         default: alu_result = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_equal <= 1'b0; alu_less <= 1'b0; alu_greater <= 1'b0;
      end else if (alu_active && alu_opcode == OP_CMP) begin
         alu_equal   <= alu_op_a == alu_op_b;
         alu_less    <= alu_op_a < alu_op_b;
         alu_greater <= alu_op_a > alu_op_b;
      end else begin
         alu_equal <= 1'b0; alu_less <= 1'b0; alu_greater <= 1'b0;
      end
   end

   task automatic drive_req(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] t);
      req_valid = 1'b1; req_opcode = op; req_op_a = a; req_op_b = b; req_tag = t;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      vectors++; if (alu_active !== 1'b0) begin miscompares++; $display("FAIL reset_alu_active got %b exp 0", alu_active); end
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
      vectors++; if (op_count !== 16'h0) begin miscompares++; $display("FAIL reset_op_count got %h exp 0000", op_count); end
      vectors++; if ({alu_op_a, alu_op_b, alu_opcode} !== 36'h0) begin miscompares++; $display("FAIL reset_alu_lines got %h exp 0", {alu_op_a, alu_op_b, alu_opcode}); end
      vectors++; if ({rsp_result, rsp_flags, rsp_tag, rsp_err} !== 24'h0) begin miscompares++; $display("FAIL reset_rsp_fields got %h exp 0", {rsp_result, rsp_flags, rsp_tag, rsp_err}); end
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
      rst_n = 1'b1;
   endtask

   task automatic test_add;
      @(negedge clk); drive_req(OP_ADD, 16'h0003, 16'h0004, 4'd5);
      vectors++; if (req_ready !== 1'b1 || alu_active !== 1'b0) begin miscompares++; $display("FAIL add_T got ready=%b active=%b exp 1 0", req_ready, alu_active); end
      @(negedge clk); req_valid = 1'b0;
      vectors++; if (alu_active !== 1'b1 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL add_T1 got active=%b valid=%b exp 1 0", alu_active, rsp_valid); end
      @(negedge clk);
      vectors++; if (alu_active !== 1'b0 || rsp_valid !== 1'b1) begin miscompares++; $display("FAIL add_T2 got active=%b valid=%b exp 0 1", alu_active, rsp_valid); end
      vectors++; if ({rsp_result, rsp_flags, rsp_tag, rsp_err} !== {16'h0007, 3'b000, 4'd5, 1'b0}) begin miscompares++; $display("FAIL add_rsp got %h/%b/%0d/%b exp 0007/000/5/0", rsp_result, rsp_flags, rsp_tag, rsp_err); end
      @(negedge clk);
      vectors++; if (op_count !== 16'd1 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL add_count got %0d valid=%b exp 1 0", op_count, rsp_valid); end
   endtask

   task automatic test_cmp;
      logic [15:0] ca [3] = '{16'h0005, 16'h1234, 16'hFFFF};
      logic [15:0] cb [3] = '{16'h0009, 16'h1234, 16'h0001};
      logic [2:0]  cf [3] = '{3'b010, 3'b001, 3'b100};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); drive_req(OP_CMP, ca[i], cb[i], 4'(i + 8));
         @(negedge clk); req_valid = 1'b0;
         vectors++; if (alu_active !== 1'b1) begin miscompares++; $display("FAIL cmp%0d_active got %b exp 1", i, alu_active); end
         @(negedge clk);
         vectors++; if (rsp_valid !== 1'b0 || alu_active !== 1'b0) begin miscompares++; $display("FAIL cmp%0d_flagcyc got valid=%b active=%b exp 0 0", i, rsp_valid, alu_active); end
         @(negedge clk);
         vectors++; if ({rsp_valid, rsp_flags, rsp_result, rsp_tag, rsp_err} !== {1'b1, cf[i], 16'h0, 4'(i + 8), 1'b0}) begin miscompares++; $display("FAIL cmp%0d_rsp got v=%b f=%b r=%h t=%0d e=%b exp v=1 f=%b r=0000 t=%0d e=0", i, rsp_valid, rsp_flags, rsp_result, rsp_tag, rsp_err, cf[i], i + 8); end
      end
      @(negedge clk);
      vectors++; if (op_count !== 16'd4) begin miscompares++; $display("FAIL cmp_count got %0d exp 4", op_count); end
   endtask

   task automatic test_back_to_back_stall;
      rsp_ready = 1'b0;
      drive_req(OP_SUB, 16'h0001, 16'h0002, 4'd3);
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk); drive_req(OP_AND, 16'h00F0, 16'h0FF0, 4'd6);
      for (int i = 0; i < 4; i++) begin
         vectors++; if ({rsp_valid, req_ready, rsp_result, rsp_tag} !== {1'b1, 1'b0, 16'hFFFF, 4'd3}) begin miscompares++; $display("FAIL stall%0d got v=%b rdy=%b r=%h t=%0d exp v=1 rdy=0 r=ffff t=3", i, rsp_valid, req_ready, rsp_result, rsp_tag); end
         @(negedge clk);
      end
      vectors++; if (op_count !== 16'd4) begin miscompares++; $display("FAIL stall_count got %0d exp 4", op_count); end
      rsp_ready = 1'b1; #1;
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release_ready got %b exp 1", req_ready); end
      @(negedge clk); req_valid = 1'b0;
      vectors++; if ({alu_active, rsp_valid, op_count} !== {1'b1, 1'b0, 16'd5}) begin miscompares++; $display("FAIL b2b_exec got a=%b v=%b c=%0d exp 1 0 5", alu_active, rsp_valid, op_count); end
      @(negedge clk);
      vectors++; if ({rsp_valid, rsp_result, rsp_tag} !== {1'b1, 16'h00F0, 4'd6}) begin miscompares++; $display("FAIL b2b_rsp got v=%b r=%h t=%0d exp 1 00f0 6", rsp_valid, rsp_result, rsp_tag); end
      @(negedge clk);
      vectors++; if (op_count !== 16'd6) begin miscompares++; $display("FAIL b2b_count got %0d exp 6", op_count); end
   endtask

   task automatic test_illegal;
      drive_req(4'b1010, 16'h1111, 16'h2222, 4'd9);
      @(negedge clk); req_valid = 1'b0;
      vectors++; if (alu_active !== 1'b0) begin miscompares++; $display("FAIL illegal_active got %b exp 0", alu_active); end
      @(negedge clk);
      vectors++; if ({rsp_valid, rsp_err, rsp_result, rsp_flags, rsp_tag} !== {1'b1, 1'b1, 16'h0, 3'b000, 4'd9}) begin miscompares++; $display("FAIL illegal_rsp got v=%b e=%b r=%h f=%b t=%0d exp 1 1 0000 000 9", rsp_valid, rsp_err, rsp_result, rsp_flags, rsp_tag); end
      @(negedge clk);
      vectors++; if (op_count !== 16'd7) begin miscompares++; $display("FAIL illegal_count got %0d exp 7", op_count); end
   endtask

   task automatic test_reset_mid;
      drive_req(OP_CMP, 16'h0005, 16'h0009, 4'd4);
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk); rst_n = 1'b0; #1;
      vectors++; if ({rsp_valid, alu_active, op_count, rsp_err, rsp_tag} !== {1'b0, 1'b0, 16'd0, 1'b0, 4'd0}) begin miscompares++; $display("FAIL midreset got v=%b a=%b c=%0d e=%b t=%0d exp 0 0 0 0 0", rsp_valid, alu_active, op_count, rsp_err, rsp_tag); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); drive_req(OP_NOT, 16'h00FF, 16'h0000, 4'd2);
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL postreset_ready got %b exp 1", req_ready); end
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk);
      vectors++; if ({rsp_valid, rsp_result, rsp_flags} !== {1'b1, 16'hFF00, 3'b000}) begin miscompares++; $display("FAIL postreset_not got v=%b r=%h f=%b exp 1 ff00 000", rsp_valid, rsp_result, rsp_flags); end
      @(negedge clk);
      vectors++; if (op_count !== 16'd1) begin miscompares++; $display("FAIL postreset_count got %0d exp 1", op_count); end
   endtask

   task automatic test_saturation;
      logic [3:0]  so [5] = '{OP_ADD, OP_MUL, OP_XOR, OP_OR, OP_NEG};
      logic [15:0] sa [5] = '{16'h7FFF, 16'h0100, 16'hAAAA, 16'h0F00, 16'h0001};
      logic [15:0] sb [5] = '{16'h0001, 16'h0100, 16'h5555, 16'h00F0, 16'h0000};
      logic [15:0] se [5] = '{16'h8000, 16'h0000, 16'hFFFF, 16'h0FF0, 16'hFFFF};
      int k;
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c % 2 == 0 && c >= 2) begin
            k = (c - 2) / 2;
            vectors++; if ({rsp_valid, req_ready, rsp_result, rsp_tag} !== {1'b1, 1'b1, se[k], 4'(k)}) begin miscompares++; $display("FAIL sat_rsp%0d got v=%b rdy=%b r=%h t=%0d exp 1 1 %h %0d", k, rsp_valid, req_ready, rsp_result, rsp_tag, se[k], k); end
            vectors++; if (s_op_count !== 2'((k > 3) ? 3 : k)) begin miscompares++; $display("FAIL sat_count%0d got %0d exp %0d", k, s_op_count, (k > 3) ? 3 : k); end
         end
         if (c % 2 == 0) begin
            if (c / 2 < 5) drive_req(so[c / 2], sa[c / 2], sb[c / 2], 4'(c / 2));
            else req_valid = 1'b0;
         end
      end
      @(negedge clk);
      vectors++; if (s_op_count !== 2'd3 || op_count !== 16'd5) begin miscompares++; $display("FAIL sat_final got sat=%0d wide=%0d exp 3 5", s_op_count, op_count); end
   endtask

   initial begin
      test_reset;
      test_add;
      test_cmp;
      test_back_to_back_stall;
      test_illegal;
      test_reset_mid;
      test_saturation;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
